// File: rtl/serial_and_reduce_if.sv
// ---------------------------------------------------------------------------
// serial_and_reduce_if
// Bundles the upstream word stream and the downstream frame-result channel
// of serial_and_reduce into one interface.
//
// Parameters:
//   WIDTH  - data word width in bits
//   CNT_W  - beat-counter width in bits
//
// Signals:
//   up_valid   upstream word present
//   up_data    upstream word (WIDTH)
//   up_last    final word of the current frame
//   up_ready   block accepts a word this cycle
//   down_valid frame result present
//   down_data  bitwise AND of all frame words (WIDTH)
//   down_count saturating number of frame words (CNT_W)
//   down_ready downstream consumes the result
//   down_or    bitwise OR of all frame words (WIDTH), only when
//              SERIAL_AND_REDUCE_OR_EN is defined
//
// Modports:
//   master - the environment: drives the upstream words, consumes results
//   slave  - the reduction block itself
// ---------------------------------------------------------------------------
interface serial_and_reduce_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             up_valid;
  logic [WIDTH-1:0] up_data;
  logic             up_last;
  logic             up_ready;
  logic             down_valid;
  logic [WIDTH-1:0] down_data;
  logic [CNT_W-1:0] down_count;
  logic             down_ready;
`ifdef SERIAL_AND_REDUCE_OR_EN
  logic [WIDTH-1:0] down_or;
`endif

  modport master (
    output up_valid, up_data, up_last, down_ready,
    input  up_ready, down_valid, down_data, down_count
`ifdef SERIAL_AND_REDUCE_OR_EN
    , input down_or
`endif
  );

  modport slave (
    input  up_valid, up_data, up_last, down_ready,
    output up_ready, down_valid, down_data, down_count
`ifdef SERIAL_AND_REDUCE_OR_EN
    , output down_or
`endif
  );
endinterface

// File: rtl/serial_and_reduce.sv
// ---------------------------------------------------------------------------
// serial_and_reduce
// Collects a frame of words one beat at a time and presents the bitwise AND
// of all the words together with a saturating word count. The result is
// held until the downstream side takes it; no new words are accepted while
// a result is pending.
//
// Optional feature: define SERIAL_AND_REDUCE_OR_EN to add bus.down_or, the
// bitwise OR of all frame words, with the same timing as the AND result.
//
// Parameters:
//   WIDTH, CNT_W - must match the parameters of the connected interface
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - serial_and_reduce_if.slave (upstream words + downstream result)
// ---------------------------------------------------------------------------
module serial_and_reduce #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_and_reduce_if.slave   bus
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] acc_reg,   acc_next;
  logic [CNT_W-1:0] cnt_reg,   cnt_next;
  logic [WIDTH-1:0] and_fold;
  logic [CNT_W-1:0] cnt_inc;

`ifdef SERIAL_AND_REDUCE_OR_EN
  logic [WIDTH-1:0] or_reg, or_next;
  logic [WIDTH-1:0] or_fold;
`endif

  // Per-bit fold of the incoming word into the running accumulators.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fold
    assign and_fold[gi] = acc_reg[gi] & bus.up_data[gi];
`ifdef SERIAL_AND_REDUCE_OR_EN
    assign or_fold[gi]  = or_reg[gi] | bus.up_data[gi];
`endif
  end

  // Count sticks at its maximum instead of wrapping back to zero.
  assign cnt_inc = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ACCUM;
      acc_reg   <= {WIDTH{1'b1}};
      cnt_reg   <= '0;
`ifdef SERIAL_AND_REDUCE_OR_EN
      or_reg    <= '0;
`endif
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
`ifdef SERIAL_AND_REDUCE_OR_EN
      or_reg    <= or_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
`ifdef SERIAL_AND_REDUCE_OR_EN
    or_next    = or_reg;
`endif
    unique case (state_reg)
      ACCUM: begin
        // up_ready is 1 throughout ACCUM, so up_valid alone is a beat.
        if (bus.up_valid) begin
          acc_next = and_fold;
          cnt_next = cnt_inc;
`ifdef SERIAL_AND_REDUCE_OR_EN
          or_next  = or_fold;
`endif
          if (bus.up_last) begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.down_ready) begin
          state_next = ACCUM;
          acc_next   = {WIDTH{1'b1}};
          cnt_next   = '0;
`ifdef SERIAL_AND_REDUCE_OR_EN
          or_next    = '0;
`endif
        end
      end
      default: begin
        state_next = ACCUM;
      end
    endcase
  end

  // Outputs come straight from state, so up_ready never sees down_ready.
  always_comb begin
    bus.up_ready   = (state_reg == ACCUM);
    bus.down_valid = (state_reg == HOLD);
    bus.down_data  = acc_reg;
    bus.down_count = cnt_reg;
`ifdef SERIAL_AND_REDUCE_OR_EN
    bus.down_or    = or_reg;
`endif
  end

endmodule

// File: tb/tb_serial_and_reduce.sv
// ---------------------------------------------------------------------------
// tb_serial_and_reduce
// Directed and random stimulus for serial_and_reduce, checked against a
// frame-level reference model (queue of accepted words, result = fold of
// the queue). Prints one line per frame result delivered.
// ---------------------------------------------------------------------------
module tb_serial_and_reduce;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  serial_and_reduce_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  serial_and_reduce #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words of the frame in progress and whether a result
  // is currently owed to the downstream side.
  logic [WIDTH-1:0] frame_q[$];
  bit               m_hold = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_and();
    logic [WIDTH-1:0] r = {WIDTH{1'b1}};
    foreach (frame_q[i]) r = r & frame_q[i];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] model_or();
    logic [WIDTH-1:0] r = '0;
    foreach (frame_q[i]) r = r | frame_q[i];
    return r;
  endfunction

  function automatic int model_cnt();
    return (frame_q.size() > CMAX) ? CMAX : frame_q.size();
  endfunction

  // Check the current outputs, then advance one clock and update the model
  // with whatever handshakes the driven inputs describe.
  task automatic cycle();
    check("up_ready", 32'(bus.up_ready), 32'(!m_hold));
    check("down_valid", 32'(bus.down_valid), 32'(m_hold));
    if (m_hold) begin
      check("down_data", 32'(bus.down_data), 32'(model_and()));
      check("down_count", 32'(bus.down_count), 32'(model_cnt()));
`ifdef SERIAL_AND_REDUCE_OR_EN
      check("down_or", 32'(bus.down_or), 32'(model_or()));
`endif
    end
    @(posedge clk);
    if (!m_hold) begin
      if (bus.up_valid) begin
        frame_q.push_back(bus.up_data);
        if (bus.up_last) m_hold = 1'b1;
      end
    end else if (bus.down_ready) begin
      $display("frame result: and=0x%0h count=%0d", model_and(), model_cnt());
      m_hold = 1'b0;
      frame_q.delete();
    end
    #1;
  endtask

  task automatic beat(input logic [WIDTH-1:0] d, input logic l);
    bus.up_valid = 1'b1;
    bus.up_data  = d;
    bus.up_last  = l;
    cycle();
    bus.up_valid = 1'b0;
    bus.up_last  = 1'b0;
  endtask

  task automatic drain();
    bus.down_ready = 1'b1;
    cycle();
    bus.down_ready = 1'b0;
  endtask

  // Assert reset between edges, check the asynchronous effect, hold it over
  // one edge, release between edges.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_up_ready", 32'(bus.up_ready), 32'd1);
    check("rst_down_valid", 32'(bus.down_valid), 32'd0);
    m_hold = 1'b0;
    frame_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    bus.up_valid   = 1'b0;
    bus.up_data    = '0;
    bus.up_last    = 1'b0;
    bus.down_ready = 1'b0;
    #2;
    check("init_up_ready", 32'(bus.up_ready), 32'd1);
    check("init_down_valid", 32'(bus.down_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Three-beat frame, no gaps; first beat right after release.
    beat(8'hF0, 1'b0);
    beat(8'hFF, 1'b0);
    beat(8'hF3, 1'b1);
    check("f3_valid", 32'(bus.down_valid), 32'd1);
    check("f3_data", 32'(bus.down_data), 32'hF0);
    check("f3_count", 32'(bus.down_count), 32'd3);
    drain();

    // Single-beat frame, then a held result with upstream pushing.
    beat(8'hA5, 1'b1);
    check("single_data", 32'(bus.down_data), 32'hA5);
    check("single_count", 32'(bus.down_count), 32'd1);
    check("single_ready", 32'(bus.up_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      bus.up_valid = 1'b1;
      bus.up_data  = 8'($urandom);
      bus.up_last  = 1'($urandom);
      cycle();
    end
    check("hold_data", 32'(bus.down_data), 32'hA5);
    bus.up_valid = 1'b0;
    bus.up_last  = 1'b0;
    drain();
    check("after_drain_ready", 32'(bus.up_ready), 32'd1);
    check("after_drain_valid", 32'(bus.down_valid), 32'd0);

    // Long frame: count saturates.
    for (int i = 0; i < 20; i++) beat(8'hFF, (i == 19));
    check("sat_count", 32'(bus.down_count), 32'd15);
    check("sat_data", 32'(bus.down_data), 32'hFF);
    drain();

    // Frame with idle gaps.
    beat(8'h7E, 1'b0);
    bus.up_data = 8'h00;
    cycle();
    cycle();
    beat(8'h3C, 1'b1);
    check("gap_data", 32'(bus.down_data), 32'h3C);
    check("gap_count", 32'(bus.down_count), 32'd2);
    drain();

    // Reset mid-frame discards the partial frame.
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    do_reset();
    beat(8'h0F, 1'b1);
    check("post_rst_data", 32'(bus.down_data), 32'h0F);
    check("post_rst_count", 32'(bus.down_count), 32'd1);

    // Reset while a result is pending drops it.
    do_reset();
    cycle();

`ifdef SERIAL_AND_REDUCE_OR_EN
    beat(8'h01, 1'b0);
    beat(8'h80, 1'b1);
    check("or_and", 32'(bus.down_data), 32'h00);
    check("or_or", 32'(bus.down_or), 32'h81);
    drain();
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      bus.up_valid   = ($urandom_range(0, 2) != 0);
      bus.up_data    = 8'($urandom);
      bus.up_last    = ($urandom_range(0, 5) == 0);
      bus.down_ready = ($urandom_range(0, 2) == 0);
      cycle();
    end
    bus.up_valid   = 1'b0;
    bus.down_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
